// File: rtl/pac_rr_sink_if.sv
// Handshake bundle between the weighted round-robin arbiter core and its sink.
//   src_valid_i  : arbiter has a granted beat pending
//   grant_i      : one-hot grant vector
//   grant_idx_i  : encoded grant index
//   sink_ready_o : registered ready returned by the sink
// Signal names keep the sink's point of view so they match the sink's port list.
// The arbiter side uses the master modport, the sink the slave modport.
interface pac_rr_sink_if #(
    parameter int unsigned N         = 4,
    parameter int unsigned IDX_WIDTH = 2
);
    logic                 src_valid_i;
    logic [N-1:0]         grant_i;
    logic [IDX_WIDTH-1:0] grant_idx_i;
    logic                 sink_ready_o;

    // Arbiter side: presents beats, observes ready.
    modport master (
        output src_valid_i,
        output grant_i,
        output grant_idx_i,
        input  sink_ready_o
    );

    // Sink side: observes beats, drives ready.
    modport slave (
        input  src_valid_i,
        input  grant_i,
        input  grant_idx_i,
        output sink_ready_o
    );
endinterface

// File: rtl/pac_rr_sink.sv
// Downstream responder for the weighted round-robin arbiter core.
// Drives a registered ready with a programmable backpressure profile, counts
// accepted beats per requester (saturating), keeps a short FIFO history of
// granted indices and flags source-side protocol violations.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   bus             : valid / grant / grant index in, registered ready out
//   cfg_mode_i      : 0 always-ready, 1 never-ready, 2 pattern, 3 LFSR
//   cfg_pattern_i   : ready duty pattern used in mode 2
//   cfg_clear_i     : pulse clearing counters, errors, FIFO, pointer and LFSR
//   hist_pop_i      : pop the history FIFO head
//   hist_data_o     : history head (0 when empty), hist_empty_o, hist_ovf_o
//   cnt_o           : packed per-requester counters, requester 0 in LSBs
//   err_o           : sticky, bit0 stability violation, bit1 grant encoding
module pac_rr_sink #(
    parameter int unsigned N          = 4,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pac_rr_sink_if.slave         bus,
    input  logic [1:0]           cfg_mode_i,
    input  logic [7:0]           cfg_pattern_i,
    input  logic                 cfg_clear_i,
    input  logic                 hist_pop_i,
    output logic [IDX_WIDTH-1:0] hist_data_o,
    output logic                 hist_empty_o,
    output logic                 hist_ovf_o,
    output logic [N*CNT_W-1:0]   cnt_o,
    output logic [1:0]           err_o
);

    localparam int unsigned PTR_W  = $clog2(HIST_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned PAT_W  = 3;
    localparam int unsigned LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        MODE_ALWAYS  = 2'd0,
        MODE_NEVER   = 2'd1,
        MODE_PATTERN = 2'd2,
        MODE_LFSR    = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Backpressure generator
    // ------------------------------------------------------------------
    mode_e             mode;
    logic              ready_q;
    logic              ready_d;
    logic [PAT_W-1:0]  ptr_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_fb;

    assign mode    = mode_e'(cfg_mode_i);
    // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3.
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // Next ready depends only on the mode and the free-running generators.
    always_comb begin
        ready_d = 1'b0;
        unique case (mode)
            MODE_ALWAYS:  ready_d = 1'b1;
            MODE_NEVER:   ready_d = 1'b0;
            MODE_PATTERN: ready_d = cfg_pattern_i[ptr_q];
            MODE_LFSR:    ready_d = lfsr_q[0];
            default:      ready_d = 1'b0;
        endcase
    end

    // Ready register; pointer and LFSR advance every cycle in every mode.
    // A clear restarts the generators but leaves this cycle's ready update alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
            ptr_q   <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            ready_q <= ready_d;
            if (cfg_clear_i) begin
                ptr_q  <= '0;
                lfsr_q <= LFSR_SEED;
            end else begin
                ptr_q  <= ptr_q + PAT_W'(1);
                lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_fb};
            end
        end
    end

    assign bus.sink_ready_o = ready_q;

    // A clear in the same cycle discards the beat.
    logic accept;
    assign accept = bus.src_valid_i & ready_q & ~cfg_clear_i;

    // ------------------------------------------------------------------
    // Per-requester saturating beat counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [N];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (cfg_clear_i) begin
                    cnt_q[i] <= '0;
                end else if (accept && (bus.grant_idx_i == IDX_WIDTH'(i)) &&
                             (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pack counters, requester 0 in the LSBs.
    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Grant history FIFO
    // ------------------------------------------------------------------
    logic [IDX_WIDTH-1:0] mem_q [HIST_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [FILL_W-1:0]    fill_q;
    logic [FILL_W-1:0]    fill_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_en;
    logic                 push_en;
    logic                 ovf_set;
    logic                 ovf_q;

    assign fifo_full  = (fill_q == FILL_W'(HIST_DEPTH));
    assign fifo_empty = (fill_q == '0);
    // Pop on empty is ignored; a pop on a full FIFO makes room for a same-cycle push.
    assign pop_en     = hist_pop_i & ~fifo_empty & ~cfg_clear_i;
    assign push_en    = accept & (~fifo_full | pop_en);
    assign ovf_set    = accept & fifo_full & ~pop_en;

    always_comb begin
        fill_d = fill_q;
        unique case ({push_en, pop_en})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
        if (cfg_clear_i) begin
            fill_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            fill_q <= fill_d;
            if (cfg_clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push_en) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_en) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                if (ovf_set) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_en) begin
            mem_q[wr_ptr_q] <= bus.grant_idx_i;
        end
    end

    assign hist_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign hist_empty_o = fifo_empty;
    assign hist_ovf_o   = ovf_q;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    logic                 pend_q;
    logic [IDX_WIDTH-1:0] pend_idx_q;
    logic [N-1:0]         grant_exp;
    logic                 stab_viol;
    logic                 enc_viol;
    logic [1:0]           err_q;

    // A stalled beat must stay valid with the same index in the following cycle.
    assign stab_viol = pend_q & (~bus.src_valid_i | (bus.grant_idx_i != pend_idx_q));
    // Grant vector must be exactly the one-hot decode of the index.
    assign grant_exp = N'(1) << bus.grant_idx_i;
    assign enc_viol  = bus.src_valid_i & (bus.grant_i != grant_exp);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            err_q      <= '0;
        end else if (cfg_clear_i) begin
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            err_q      <= '0;
        end else begin
            pend_q     <= bus.src_valid_i & ~ready_q;
            pend_idx_q <= bus.grant_idx_i;
            err_q      <= err_q | {enc_viol, stab_viol};
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_pac_rr_sink.sv
// Directed bench for pac_rr_sink: stimulus pushes expected ready values and
// expected history pops into queues; a negedge monitor pops and compares.
module tb_pac_rr_sink;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 8;
    localparam int unsigned HD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pac_rr_sink_if #(.N(N), .IDX_WIDTH(IW)) bus ();

    logic [1:0]    cfg_mode;
    logic [7:0]    cfg_pattern;
    logic          cfg_clear;
    logic          hist_pop;
    logic [IW-1:0] hist_data;
    logic          hist_empty;
    logic          hist_ovf;
    logic [N*CW-1:0] cnt;
    logic [1:0]    err;

    pac_rr_sink #(.N(N), .IDX_WIDTH(IW), .CNT_W(CW), .HIST_DEPTH(HD)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus          (bus),
        .cfg_mode_i   (cfg_mode),
        .cfg_pattern_i(cfg_pattern),
        .cfg_clear_i  (cfg_clear),
        .hist_pop_i   (hist_pop),
        .hist_data_o  (hist_data),
        .hist_empty_o (hist_empty),
        .hist_ovf_o   (hist_ovf),
        .cnt_o        (cnt),
        .err_o        (err)
    );

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] exp_hist [$];
    logic          exp_ready [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] idx, input logic [N-1:0] g);
        bus.src_valid_i = v;
        bus.grant_idx_i = idx;
        bus.grant_i     = g;
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    // Scoreboard monitor: compares history head on every effective pop and
    // ready against the expected sequence while one is queued.
    always @(negedge clk) begin
        if (rst_n && hist_pop && !hist_empty) begin
            if (exp_hist.size() == 0)
                check("hist_pop_unexpected", 32'(exp_hist.size()), 32'd1);
            else
                check("hist_pop_data", 32'(hist_data), 32'(exp_hist.pop_front()));
        end
        if (exp_ready.size() != 0) begin
            check("ready_seq", 32'(bus.sink_ready_o), 32'(exp_ready.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] l;
        cfg_mode    = 2'd0;
        cfg_pattern = 8'h00;
        cfg_clear   = 1'b0;
        hist_pop    = 1'b0;
        drive(1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (2) tick();

        // Reset values
        check("rst_ready", 32'(bus.sink_ready_o), 32'd0);
        check("rst_cnt",   cnt, 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_empty", 32'(hist_empty), 32'd1);
        check("rst_data",  32'(hist_data), 32'd0);
        check("rst_ovf",   32'(hist_ovf), 32'd0);

        // Mode 0: first ready in cycle 1, five beats on idx 2
        rst_n = 1'b1;
        tick();
        check("m0_ready_cycle1", 32'(bus.sink_ready_o), 32'd1);
        drive(1'b1, 2'd2, 4'b0100);
        repeat (5) tick();
        drive(1'b0, '0, '0);
        check("m0_cnt",   cnt, 32'h0005_0000);
        check("m0_ovf",   32'(hist_ovf), 32'd1);
        check("m0_err",   32'(err), 32'd0);
        check("m0_empty", 32'(hist_empty), 32'd0);
        repeat (4) exp_hist.push_back(2'd2);
        hist_pop = 1'b1;
        repeat (4) tick();
        hist_pop = 1'b0;
        check("m0_drained", 32'(hist_empty), 32'd1);
        pulse_clear();

        // Mode 2: pattern 0x55, 16 cycles of valid on idx 1
        cfg_mode    = 2'd2;
        cfg_pattern = 8'h55;
        pulse_clear();
        tick();
        for (int i = 0; i < 16; i++) exp_ready.push_back((i % 2) == 0);
        drive(1'b1, 2'd1, 4'b0010);
        repeat (16) tick();
        drive(1'b0, '0, '0);
        check("m2_cnt", cnt, 32'h0000_0800);
        check("m2_err_before_drop", 32'(err), 32'd0);
        tick();
        // Last cycle was stalled, so dropping valid is a stability violation
        check("m2_err_after_drop", 32'(err), 32'd1);
        pulse_clear();

        // Mode 1: stalled beat withdrawn -> stability error, then clear
        cfg_mode = 2'd1;
        tick();
        drive(1'b1, 2'd0, 4'b0001);
        tick();
        drive(1'b0, '0, '0);
        tick();
        check("m1_err", 32'(err), 32'd1);
        check("m1_cnt", cnt, 32'd0);
        pulse_clear();
        check("clr_err",   32'(err), 32'd0);
        check("clr_cnt",   cnt, 32'd0);
        check("clr_empty", 32'(hist_empty), 32'd1);

        // Mode 0: grant vector disagrees with index; beat still counted
        cfg_mode = 2'd0;
        tick();
        drive(1'b1, 2'd3, 4'b0001);
        tick();
        drive(1'b0, '0, '0);
        check("enc_err",  32'(err), 32'd2);
        check("enc_cnt",  cnt, 32'h0100_0000);
        check("enc_hist", 32'(hist_data), 32'd3);
        pulse_clear();

        // Saturation on idx 0
        drive(1'b1, 2'd0, 4'b0001);
        repeat (255) tick();
        check("sat_at_255", cnt, 32'h0000_00FF);
        repeat (5) tick();
        check("sat_hold", cnt, 32'h0000_00FF);
        // Clear wins over a same-cycle accept
        pulse_clear();
        drive(1'b0, '0, '0);
        check("clr_wins_cnt",   cnt, 32'd0);
        check("clr_wins_empty", 32'(hist_empty), 32'd1);

        // FIFO: fill 0..3, then simultaneous push/pop on full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, IW'(i), N'(1) << i);
            tick();
        end
        check("fill_empty", 32'(hist_empty), 32'd0);
        check("fill_ovf",   32'(hist_ovf), 32'd0);
        drive(1'b1, 2'd0, 4'b0001);
        hist_pop = 1'b1;
        exp_hist.push_back(2'd0);
        tick();
        drive(1'b0, '0, '0);
        exp_hist.push_back(2'd1);
        exp_hist.push_back(2'd2);
        exp_hist.push_back(2'd3);
        exp_hist.push_back(2'd0);
        repeat (4) tick();
        hist_pop = 1'b0;
        check("pp_ovf",   32'(hist_ovf), 32'd0);
        check("pp_empty", 32'(hist_empty), 32'd1);
        hist_pop = 1'b1;
        tick();
        hist_pop = 1'b0;
        check("pop_empty_ignored", 32'(hist_empty), 32'd1);
        check("pop_empty_data",    32'(hist_data), 32'd0);
        check("hist_sb_drained",   32'(exp_hist.size()), 32'd0);

        // Mode 3 from reset: ready follows LFSR seeded with 0xA5
        rst_n    = 1'b0;
        cfg_mode = 2'd3;
        tick();
        rst_n = 1'b1;
        tick();
        l = 8'hA5;
        for (int i = 0; i < 24; i++) begin
            exp_ready.push_back(l[0]);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        repeat (24) tick();
        check("lfsr_sb_drained", 32'(exp_ready.size()), 32'd0);

        // Asynchronous reset mid-stream
        cfg_mode = 2'd0;
        tick();
        drive(1'b1, 2'd2, 4'b0100);
        repeat (5) tick();
        drive(1'b1, 2'd1, 4'b0011);
        tick();
        drive(1'b1, 2'd2, 4'b0100);
        check("pre_rst_err",   32'(err), 32'd2);
        check("pre_rst_ovf",   32'(hist_ovf), 32'd1);
        check("pre_rst_ready", 32'(bus.sink_ready_o), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.sink_ready_o), 32'd0);
        check("arst_cnt",   cnt, 32'd0);
        check("arst_err",   32'(err), 32'd0);
        check("arst_empty", 32'(hist_empty), 32'd1);
        check("arst_data",  32'(hist_data), 32'd0);
        check("arst_ovf",   32'(hist_ovf), 32'd0);
        drive(1'b0, '0, '0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pac_rr_sink.md
Name: pac_rr_sink

Overview:
Downstream responder for the weighted round-robin arbiter core. It consumes granted transfers and drives a registered sink_ready with a programmable backpressure profile. It checks the source-side valid/grant protocol, counts accepted beats per requester, and keeps a short history of granted indices.
It sits between the arbiter core and the peripheral register map, replacing the testbench-driven ready stub.

Parameters:
N, 4, number of requesters
IDX_WIDTH, 2, width of grant index (log2 N)
CNT_W, 8, width of each per-requester beat counter
HIST_DEPTH, 4, history FIFO entries (power of two)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
src_valid_i  input  1  arbiter has a granted beat pending
grant_i  input  N  one-hot grant vector from arbiter
grant_idx_i  input  IDX_WIDTH  encoded grant index
sink_ready_o  output  1  registered ready to arbiter
cfg_mode_i  input  2  0 always-ready, 1 never-ready, 2 pattern, 3 LFSR
cfg_pattern_i  input  8  ready duty pattern for mode 2
cfg_clear_i  input  1  one-cycle pulse: clear counters, errors, FIFO, reseed LFSR, reset pattern pointer
hist_pop_i  input  1  pop history FIFO head
hist_data_o  output  IDX_WIDTH  history FIFO head, 0 when empty
hist_empty_o  output  1  FIFO empty
hist_ovf_o  output  1  sticky: accepted beat arrived while FIFO full
cnt_o  output  N*CNT_W  packed per-requester accepted-beat counters, requester 0 in LSBs
err_o  output  2  sticky: bit0 stability violation, bit1 grant encoding violation

Behaviour:
- Reset: sink_ready_o=0, cnt_o=0, err_o=0, FIFO empty (hist_empty_o=1, hist_data_o=0), hist_ovf_o=0, pattern pointer=0, LFSR=8'hA5.
- Accept when src_valid_i & sink_ready_o in the same cycle.
- sink_ready_o is a flop. It never depends combinationally on src_valid_i or grant inputs. Its next value is computed from cfg_mode_i only:
  - mode 0: 1
  - mode 1: 0
  - mode 2: cfg_pattern_i[ptr]; 3-bit ptr increments every cycle and wraps 7->0
  - mode 3: lfsr[0]; 8-bit Fibonacci LFSR, taps 8,6,5,4, shifts every cycle
- The pointer and LFSR advance in all modes. A mode change is visible on sink_ready_o one cycle later. First ready after reset is in cycle 1.
- Counters: on accept, cnt[grant_idx_i] increments. Each counter saturates at all-ones and does not wrap.
- History FIFO:
  - On accept, push grant_idx_i if not full. If full, drop the beat and set hist_ovf_o.
  - hist_pop_i when empty is ignored.
  - Push and pop in the same cycle on a full FIFO: the pop frees space, the push succeeds, no overflow.
  - Push and pop on an empty FIFO: the pop is ignored, the push succeeds.
  - hist_data_o shows the head combinationally from FIFO storage.
- err_o[0]: set if, in cycle t, src_valid_i=1 and sink_ready_o=0, and in cycle t+1 either src_valid_i=0 or grant_idx_i differs from its value at t.
- err_o[1]: set in any cycle with src_valid_i=1 where grant_i != (1 << grant_idx_i). This includes zero and multi-hot grant_i.
- cfg_clear_i priority:
  - Clears counters, err_o, FIFO, hist_ovf_o and the stability tracker; sets ptr=0 and LFSR=8'hA5.
  - Wins over a same-cycle accept: that beat is not counted or pushed.
  - Does not change sink_ready_o in that cycle. The next ready uses the cleared ptr/LFSR.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous). The source must re-present pending beats.

Test Plan:
- Mode 0, assert valid with grant_idx=2, grant_i=4'b0100 for 5 cycles -> sink_ready_o=1 from cycle 1; cnt[2]=5, others 0; FIFO holds four 2s; hist_ovf_o=1; err_o=0.
- Mode 2, pattern 8'b0101_0101, valid held on idx 1 for 16 cycles -> ready alternates 1,0,... starting ptr0=1; exactly 8 accepts; cnt[1]=8.
- Mode 1, valid on idx 0; next cycle drop valid -> err_o=2'b01. Then cfg_clear_i -> err_o=0, cnt all 0, hist_empty_o=1.
- Mode 0, valid with grant_idx=3 and grant_i=4'b0001 -> err_o[1]=1; beat still counted in cnt[3].
- Drive 260 accepts on idx 0 -> cnt[0] saturates at 8'hFF.
- Fill FIFO (idx 0,1,2,3), then pop while accepting idx 0 -> no overflow; pops return 1,2,3,0, then hist_empty_o=1.
- Mode 3 from reset -> ready sequence matches the LFSR model seeded with 8'hA5.
- Reset asserted mid-stream -> all outputs return to reset values immediately, without waiting for a clock edge.
